// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and restoring divide producing {hi, lo}.
// One bit per cycle over WIDTH cycles with a start/busy/done handshake.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic                 is_signed;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH-1:0]     mul_hi_nx, mul_lo_nx;
    logic [2*WIDTH-1:0]   prod, prod_fix;
    logic [WIDTH:0]       div_shift, div_trial;
    logic [WIDTH-1:0]     div_hi_nx, div_lo_nx;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic                 last_iter;

    // Magnitudes: negating the most negative value yields 2^(WIDTH-1) read as unsigned.
    assign is_signed = ~op[0];
    assign mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;

    // Shift-add: lo holds the remaining multiplier bits, hi accumulates the product top.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
    assign prod      = {mul_hi_nx, mul_lo_nx};
    assign prod_fix  = neg_q ? -prod : prod;

    // Restoring step: bit WIDTH of the trial difference is the borrow.
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opb_q};
    assign div_hi_nx = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign div_lo_nx = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    assign quo_fix   = neg_q ? -div_lo_nx : div_lo_nx;
    assign rem_fix   = neg_rem_q ? -div_hi_nx : div_hi_nx;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    dbz_d     = 1'b0;
                    cnt_d     = '0;
                    hi_d      = '0;
                    neg_d     = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = is_signed & a[WIDTH-1];
                    if (!op[1]) begin
                        state_d = S_MUL;
                        lo_d    = mag_b;
                        opb_d   = mag_a;
                    end else if (b == '0) begin
                        result_d = {a, {WIDTH{1'b1}}};
                        dbz_d    = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_DIV;
                        lo_d    = mag_a;
                        opb_d   = mag_b;
                    end
                end
            end
            S_MUL: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = mul_hi_nx;
                    lo_d  = mul_lo_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (last_iter) begin
                        state_d  = S_IDLE;
                        result_d = prod_fix;
                        done_d   = 1'b1;
                        dbz_d    = 1'b0;
                    end
                end
            end
            S_DIV: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = div_hi_nx;
                    lo_d  = div_lo_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (last_iter) begin
                        state_d  = S_IDLE;
                        result_d = {rem_fix, quo_fix};
                        done_d   = 1'b1;
                        dbz_d    = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule
